// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the 2-lane PHY RX symbol-lock / deskew path.
//   lane_state_t      : per-lane lock FSM state (SEARCH / ALIGN / LOCKED)
//   COM_K28_5         : comma / alignment symbol value
//   COM_COUNT_DEFAULT : consecutive COMs needed before a lane is locked
// -----------------------------------------------------------------------------
package phy_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } lane_state_t;

  localparam logic [7:0] COM_K28_5         = 8'hBC;
  localparam int         COM_COUNT_DEFAULT = 4;

endpackage

// File: rtl/phy_rx_lane_sync.sv
// -----------------------------------------------------------------------------
// phy_rx_lane_sync
// Per-lane byte lock: serial shift register, bit counter, SEARCH/ALIGN/LOCKED
// FSM, COM counter and one-byte hold register with its flag.
// Ports:
//   clk       : bit clock
//   srst      : synchronous active-high reset
//   din       : serial bit, MSB first
//   flush     : drop lock, return to SEARCH, clear hold flag (resync / skew)
//   hold_clr  : held byte consumed by the pairing logic
//   byte_done : a byte completes on this edge while LOCKED
//   is_com    : the byte formed on this edge equals COM_CHAR
//   locked    : lane is in LOCKED
//   hold_byte : last non-COM byte captured while LOCKED
//   hold_flag : hold_byte is valid and not yet paired
// -----------------------------------------------------------------------------
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_CHAR  = COM_K28_5,
  parameter int         COM_COUNT = COM_COUNT_DEFAULT
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       din,
  input  logic       flush,
  input  logic       hold_clr,
  output logic       byte_done,
  output logic       is_com,
  output logic       locked,
  output logic [7:0] hold_byte,
  output logic [7:0] hold_byte_unused_guard,
  output logic       hold_flag
);

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  lane_state_t state_reg, state_next;
  logic [7:0]  sh_reg, sh_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [3:0]  com_cnt_reg, com_cnt_next;
  logic [7:0]  hold_byte_reg, hold_byte_next;
  logic        hold_flag_reg, hold_flag_next;
  logic        boundary;
  logic        com_hit;

  // Every decision looks at the byte that includes the bit being sampled now,
  // so a byte is judged on the same edge that captures its last bit.
  assign sh_next  = {sh_reg[6:0], din};
  assign com_hit  = (sh_next == COM_CHAR);
  assign boundary = (bit_cnt_reg == 3'd7);

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg + 3'd1;
    com_cnt_next   = com_cnt_reg;
    hold_byte_next = hold_byte_reg;
    hold_flag_next = hold_clr ? 1'b0 : hold_flag_reg;

    case (state_reg)
      SEARCH: begin
        // Sliding match: a hit defines the byte boundary.
        if (com_hit) begin
          bit_cnt_next = 3'd0;
          com_cnt_next = 4'd1;
          state_next   = (COM_COUNT == 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (com_hit) begin
            com_cnt_next = com_cnt_reg + 4'd1;
            if (com_cnt_reg + 4'd1 == COM_TARGET) begin
              state_next = LOCKED;
            end
          end else begin
            com_cnt_next = 4'd0;
            state_next   = SEARCH;
          end
        end
      end
      LOCKED: begin
        // COMs are skip symbols; only data bytes are held. A new byte wins
        // over a same-edge hold_clr so back-to-back bytes are not lost.
        if (boundary && !com_hit) begin
          hold_byte_next = sh_next;
          hold_flag_next = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase

    if (flush) begin
      state_next     = SEARCH;
      com_cnt_next   = 4'd0;
      hold_flag_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= SEARCH;
      sh_reg        <= 8'd0;
      bit_cnt_reg   <= 3'd0;
      com_cnt_reg   <= 4'd0;
      hold_byte_reg <= 8'd0;
      hold_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sh_reg        <= sh_next;
      bit_cnt_reg   <= bit_cnt_next;
      com_cnt_reg   <= com_cnt_next;
      hold_byte_reg <= hold_byte_next;
      hold_flag_reg <= hold_flag_next;
    end
  end

  assign byte_done             = (state_reg == LOCKED) && boundary;
  assign is_com                = com_hit;
  assign locked                = (state_reg == LOCKED);
  assign hold_byte             = hold_byte_reg;
  assign hold_byte_unused_guard = sh_next;
  assign hold_flag             = hold_flag_reg;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_sync_ctrl
// Two-lane RX symbol lock and deskew. Each lane locks on COM_CHAR; data bytes
// held by both lanes are emitted together as a pair.
// Ports:
//   clk_32f                  : bit clock (one bit per lane per cycle)
//   reset                    : synchronous active-high reset
//   data_in_0 / data_in_1    : serial lane inputs, MSB first
//   resync                   : one-cycle request to drop lock and re-search
//   lane_byte_0/lane_byte_1  : bytes of the last emitted pair (held)
//   pair_valid               : one-cycle strobe for lane_byte_0/1
//   lock_0 / lock_1          : lane is LOCKED
//   active                   : both lanes locked, one cycle behind lock_x
//   skew_err                 : sticky lane-skew error
// -----------------------------------------------------------------------------
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_CHAR  = COM_K28_5,
  parameter int         COM_COUNT = COM_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in_0,
  input  logic       data_in_1,
  input  logic       resync,
  output logic [7:0] lane_byte_0,
  output logic [7:0] lane_byte_1,
  output logic       pair_valid,
  output logic       lock_0,
  output logic       lock_1,
  output logic       active,
  output logic       skew_err
);

  logic [1:0]      din;
  logic [1:0]      byte_done;
  logic [1:0]      is_com;
  logic [1:0]      locked;
  logic [1:0]      hold_flag;
  logic [1:0]      skew_hit;
  logic [1:0][7:0] hold_byte;
  logic [1:0][7:0] cur_byte;
  logic            pair_fire;
  logic            skew_det;
  logic            flush;

  assign din       = {data_in_1, data_in_0};
  assign pair_fire = hold_flag[0] & hold_flag[1];
  assign skew_det  = |skew_hit;
  assign flush     = resync | skew_det;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      phy_rx_lane_sync #(
        .COM_CHAR  (COM_CHAR),
        .COM_COUNT (COM_COUNT)
      ) u_lane (
        .clk                   (clk_32f),
        .srst                  (reset),
        .din                   (din[gi]),
        .flush                 (flush),
        .hold_clr              (pair_fire),
        .byte_done             (byte_done[gi]),
        .is_com                (is_com[gi]),
        .locked                (locked[gi]),
        .hold_byte             (hold_byte[gi]),
        .hold_byte_unused_guard(cur_byte[gi]),
        .hold_flag             (hold_flag[gi])
      );

      // A lane finishing a second data byte before its partner delivered the
      // first means the lanes are a full byte or more apart.
      assign skew_hit[gi] = byte_done[gi] & ~is_com[gi] & hold_flag[gi]
                            & ~hold_flag[1-gi] & (cur_byte[gi] != COM_CHAR);
    end
  endgenerate

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      lane_byte_0 <= 8'd0;
      lane_byte_1 <= 8'd0;
      pair_valid  <= 1'b0;
      active      <= 1'b0;
      skew_err    <= 1'b0;
    end else if (resync) begin
      // resync outranks a pair completing on the same edge
      pair_valid <= 1'b0;
      active     <= 1'b0;
      skew_err   <= 1'b0;
    end else begin
      pair_valid <= pair_fire;
      if (pair_fire) begin
        lane_byte_0 <= hold_byte[0];
        lane_byte_1 <= hold_byte[1];
      end
      if (skew_det) begin
        skew_err <= 1'b1;
      end
      active <= locked[0] & locked[1];
    end
  end

  assign lock_0 = locked[0];
  assign lock_1 = locked[1];

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_sync_ctrl
// Directed bench: serial lane streams built from byte lists, per-edge capture
// of the outputs, then checks against hand-computed edge indices and values.
// Edge index i is the rising edge that samples stream bit i.
// -----------------------------------------------------------------------------
module tb_phy_rx_sync_ctrl;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b1;
  logic       data_in_0 = 1'b0;
  logic       data_in_1 = 1'b0;
  logic       resync = 1'b0;
  logic [7:0] lane_byte_0, lane_byte_1;
  logic       pair_valid, lock_0, lock_1, active, skew_err;

  phy_rx_sync_ctrl #(
    .COM_CHAR  (8'hBC),
    .COM_COUNT (4)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .resync     (resync),
    .lane_byte_0(lane_byte_0),
    .lane_byte_1(lane_byte_1),
    .pair_valid (pair_valid),
    .lock_0     (lock_0),
    .lock_1     (lock_1),
    .active     (active),
    .skew_err   (skew_err)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  localparam int MAXI = 160;
  logic       lock0_at [MAXI];
  logic       lock1_at [MAXI];
  logic       active_at[MAXI];
  logic       skew_at  [MAXI];
  logic       pv_at    [MAXI];
  logic [7:0] lb0_at   [MAXI];
  logic [7:0] lb1_at   [MAXI];

  typedef struct {
    int         idx;
    logic [7:0] b0;
    logic [7:0] b1;
  } pair_t;
  pair_t pairs[$];

  logic [7:0] pay0[$];
  logic [7:0] pay1[$];
  int         delay1 = 0;

  // Lane bit j of the stream; past the payload the lane idles on COMs.
  function automatic logic get_bit(input int lane, input int i);
    int         j;
    logic [7:0] b;
    j = (lane == 1) ? i - delay1 : i;
    if (j < 0) return 1'b0;
    if (lane == 0) b = (j / 8 < pay0.size()) ? pay0[j / 8] : 8'hBC;
    else           b = (j / 8 < pay1.size()) ? pay1[j / 8] : 8'hBC;
    return b[7 - (j % 8)];
  endfunction

  task automatic do_reset();
    reset = 1'b1; resync = 1'b0; data_in_0 = 1'b0; data_in_1 = 1'b0;
    @(posedge clk_32f); #1;
    reset = 1'b0;
  endtask

  task automatic run_stream(input int ncyc, input int rs_at, input int rst_at);
    pairs.delete();
    for (int i = 0; i < ncyc; i++) begin
      data_in_0 = get_bit(0, i);
      data_in_1 = get_bit(1, i);
      resync    = (i == rs_at);
      reset     = (i == rst_at);
      @(posedge clk_32f); #1;
      lock0_at[i]  = lock_0;
      lock1_at[i]  = lock_1;
      active_at[i] = active;
      skew_at[i]   = skew_err;
      pv_at[i]     = pair_valid;
      lb0_at[i]    = lane_byte_0;
      lb1_at[i]    = lane_byte_1;
      if (pair_valid) pairs.push_back('{i, lane_byte_0, lane_byte_1});
      $display("edge %0d: lock=%b%b active=%b pv=%b bytes=%h/%h skew=%b",
               i, lock_0, lock_1, active, pair_valid, lane_byte_0, lane_byte_1, skew_err);
    end
    resync = 1'b0;
    reset  = 1'b0;
  endtask

  localparam logic [7:0] EXP_B0[6] = '{8'hAA, 8'hAA, 8'h77, 8'h77, 8'h66, 8'h66};
  localparam logic [7:0] EXP_B1[6] = '{8'h66, 8'h66, 8'hDD, 8'hDD, 8'h33, 8'h33};

  task automatic check_pairs(input string tag, input int exp_idx[6]);
    logic [7:0] e0, e1;
    check_eq({tag, "_count"}, pairs.size(), 6);
    for (int k = 0; k < 6 && k < pairs.size(); k++) begin
      e0 = EXP_B0[k];
      e1 = EXP_B1[k];
      check_eq($sformatf("%s_idx%0d", tag, k), pairs[k].idx, exp_idx[k]);
      check_eq($sformatf("%s_b0_%0d", tag, k), pairs[k].b0, e0);
      check_eq($sformatf("%s_b1_%0d", tag, k), pairs[k].b1, e1);
    end
  endtask

  task automatic load_base(input logic mid_com, input int n_com);
    pay0.delete(); pay1.delete();
    for (int k = 0; k < n_com; k++) begin
      pay0.push_back(8'hBC); pay1.push_back(8'hBC);
    end
    for (int k = 0; k < 6; k++) begin
      if (mid_com && k == 2) begin
        pay0.push_back(8'hBC); pay1.push_back(8'hBC);
      end
      pay0.push_back(EXP_B0[k]); pay1.push_back(EXP_B1[k]);
    end
  endtask

  initial begin
    int ones;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk_32f);
    #1;
    check_eq("rst_lock0", lock_0, 1'b0);
    check_eq("rst_lock1", lock_1, 1'b0);
    check_eq("rst_active", active, 1'b0);
    check_eq("rst_pv", pair_valid, 1'b0);
    check_eq("rst_skew", skew_err, 1'b0);
    check_eq("rst_bytes", {lane_byte_0, lane_byte_1}, 16'h0000);

    // 1: lanes in phase
    do_reset(); delay1 = 0; load_base(1'b0, 4);
    run_stream(96, -1, -1);
    check_eq("t1_lock0_pre", lock0_at[30], 1'b0);
    check_eq("t1_lock0", lock0_at[31], 1'b1);
    check_eq("t1_lock1", lock1_at[31], 1'b1);
    check_eq("t1_active_pre", active_at[31], 1'b0);
    check_eq("t1_active", active_at[32], 1'b1);
    check_pairs("t1", '{40, 48, 56, 64, 72, 80});
    check_eq("t1_hold_b0", lb0_at[45], 8'hAA);
    check_eq("t1_hold_pv", pv_at[45], 1'b0);
    ones = 0;
    for (int i = 0; i < 96; i++) ones += int'(skew_at[i]);
    check_eq("t1_no_skew", ones, 0);

    // 2: only three COMs, never locks
    do_reset(); delay1 = 0; load_base(1'b0, 3);
    run_stream(96, -1, -1);
    ones = 0;
    for (int i = 0; i < 96; i++)
      ones += int'(lock0_at[i] | lock1_at[i] | active_at[i] | pv_at[i]);
    check_eq("t2_no_lock", ones, 0);

    // 3: lane 1 three bits late
    do_reset(); delay1 = 3; load_base(1'b0, 4);
    run_stream(96, -1, -1);
    check_eq("t3_lock0", lock0_at[31], 1'b1);
    check_eq("t3_lock1_pre", lock1_at[33], 1'b0);
    check_eq("t3_lock1", lock1_at[34], 1'b1);
    check_eq("t3_active_pre", active_at[34], 1'b0);
    check_eq("t3_active", active_at[35], 1'b1);
    check_pairs("t3", '{43, 51, 59, 67, 75, 83});

    // 4: lane 1 nine bits late -> skew on lane 0's second data byte
    do_reset(); delay1 = 9; load_base(1'b0, 4);
    run_stream(100, -1, -1);
    check_eq("t4_lock1", lock1_at[40], 1'b1);
    check_eq("t4_active", active_at[41], 1'b1);
    check_eq("t4_skew_pre", skew_at[46], 1'b0);
    check_eq("t4_skew", skew_at[47], 1'b1);
    check_eq("t4_lock0_pre", lock0_at[46], 1'b1);
    check_eq("t4_lock0_drop", lock0_at[47], 1'b0);
    check_eq("t4_lock1_drop", lock1_at[47], 1'b0);
    check_eq("t4_active_drop", active_at[48], 1'b0);
    check_eq("t4_no_pairs", pairs.size(), 0);
    check_eq("t4_skew_sticky", skew_at[99], 1'b1);

    // 5: mid-stream COM skipped, then resync and relock
    do_reset(); delay1 = 0; load_base(1'b1, 4);
    run_stream(136, 100, -1);
    check_pairs("t5", '{40, 48, 64, 72, 80, 88});
    check_eq("t5_lock0_held", lock0_at[99], 1'b1);
    check_eq("t5_lock1_held", lock1_at[99], 1'b1);
    check_eq("t5_rs_lock0", lock0_at[100], 1'b0);
    check_eq("t5_rs_lock1", lock1_at[100], 1'b0);
    check_eq("t5_rs_active", active_at[100], 1'b0);
    check_eq("t5_rs_skew", skew_at[100], 1'b0);
    check_eq("t5_relock_pre", lock0_at[126], 1'b0);
    check_eq("t5_relock0", lock0_at[127], 1'b1);
    check_eq("t5_relock1", lock1_at[127], 1'b1);
    check_eq("t5_reactive", active_at[128], 1'b1);

    // 6: reset during the 3rd pair
    do_reset(); delay1 = 0; load_base(1'b0, 4);
    run_stream(120, -1, 56);
    check_eq("t6_pv", pv_at[56], 1'b0);
    check_eq("t6_bytes", {lb0_at[56], lb1_at[56]}, 16'h0000);
    check_eq("t6_lock0", lock0_at[56], 1'b0);
    check_eq("t6_active", active_at[56], 1'b0);
    check_eq("t6_pairs", pairs.size(), 2);
    check_eq("t6_relock_pre", lock0_at[110], 1'b0);
    check_eq("t6_relock", lock0_at[111], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
